// File: rtl/calculator_pkg.sv
// Shared parameters, FSM state encoding and the write-data masking helper
// for the calculator datapath.
package calculator_pkg;

  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 2 * DATA_W;
  localparam int ADDR_W        = 10;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WCNT_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    ADD   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } calc_state_t;

  // An odd final word leaves the upper buffer half stale, so it is forced to zero.
  function automatic logic [MEM_WORD_SIZE-1:0] mask_upper(
    input logic [MEM_WORD_SIZE-1:0] word,
    input logic                     keep_upper
  );
    return keep_upper ? word : {{DATA_W{1'b0}}, word[DATA_W-1:0]};
  endfunction

endpackage

// File: rtl/calc_controller.sv
// Sequencer: reads operand words, feeds the adder, steers sums into result_buffer
// and writes filled buffers back. Optional macro CALC_CTRL_WORD_COUNT_EN adds words_written_o.
module calc_controller
  import calculator_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        read_start_addr_i,
  input  logic [ADDR_W-1:0]        read_end_addr_i,
  input  logic [ADDR_W-1:0]        write_start_addr_i,
  output logic                     mem_re_o,
  output logic                     mem_we_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i,
  output logic [MEM_WORD_SIZE-1:0] mem_wdata_o,
  output logic [DATA_W-1:0]        op_a_o,
  output logic [DATA_W-1:0]        op_b_o,
  output logic                     loc_sel_o,
  input  logic [MEM_WORD_SIZE-1:0] buffer_i,
  output logic                     busy_o,
  output logic                     done_o
`ifdef CALC_CTRL_WORD_COUNT_EN
  ,
  output logic [ADDR_W:0]          words_written_o
`endif
);

  calc_state_t       r_state;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_end_addr;
  logic              r_half;
  logic              r_mem_re;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_loc_sel;
  logic              r_busy;
  logic              r_done;
`ifdef CALC_CTRL_WORD_COUNT_EN
  logic [ADDR_W:0]   r_words;
`endif

  logic w_in_add;
  logic w_in_write;

  assign w_in_add   = (r_state == ADD);
  assign w_in_write = (r_state == WRITE);

  // Read data and buffer contents are only valid inside their own state, so these pass straight through.
  assign op_a_o      = w_in_add   ? mem_rdata_i[DATA_W-1:0]            : {DATA_W{1'b0}};
  assign op_b_o      = w_in_add   ? mem_rdata_i[MEM_WORD_SIZE-1:DATA_W] : {DATA_W{1'b0}};
  assign mem_wdata_o = w_in_write ? mask_upper(buffer_i, r_half)        : {MEM_WORD_SIZE{1'b0}};

  assign mem_re_o   = r_mem_re;
  assign mem_we_o   = r_mem_we;
  assign mem_addr_o = r_mem_addr;
  assign loc_sel_o  = r_loc_sel;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
`ifdef CALC_CTRL_WORD_COUNT_EN
  assign words_written_o = r_words;
`endif

  // Control outputs are computed for the state being entered so they come straight from flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_rd_ptr   <= {ADDR_W{1'b0}};
      r_wr_ptr   <= {ADDR_W{1'b0}};
      r_end_addr <= {ADDR_W{1'b0}};
      r_half     <= 1'b0;
      r_mem_re   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= {ADDR_W{1'b0}};
      r_loc_sel  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef CALC_CTRL_WORD_COUNT_EN
      r_words    <= {(ADDR_W + 1){1'b0}};
`endif
    end else begin
      r_mem_re <= 1'b0;
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_rd_ptr   <= read_start_addr_i;
            r_wr_ptr   <= write_start_addr_i;
            r_end_addr <= read_end_addr_i;
            r_half     <= 1'b0;
            r_busy     <= 1'b1;
`ifdef CALC_CTRL_WORD_COUNT_EN
            r_words    <= {(ADDR_W + 1){1'b0}};
`endif
            if (read_end_addr_i < read_start_addr_i) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= READ;
              r_mem_re   <= 1'b1;
              r_mem_addr <= read_start_addr_i;
            end
          end
        end
        READ: begin
          r_state   <= ADD;
          r_loc_sel <= r_half;
        end
        ADD: begin
          if (!r_half && (r_rd_ptr != r_end_addr)) begin
            r_half     <= 1'b1;
            r_rd_ptr   <= r_rd_ptr + ADDR_ONE;
            r_state    <= READ;
            r_mem_re   <= 1'b1;
            r_mem_addr <= r_rd_ptr + ADDR_ONE;
          end else begin
            r_state    <= WRITE;
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_wr_ptr;
          end
        end
        WRITE: begin
          r_wr_ptr <= r_wr_ptr + ADDR_ONE;
          r_half   <= 1'b0;
`ifdef CALC_CTRL_WORD_COUNT_EN
          r_words  <= r_words + WCNT_ONE;
`endif
          if (r_rd_ptr == r_end_addr) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_rd_ptr   <= r_rd_ptr + ADDR_ONE;
            r_state    <= READ;
            r_mem_re   <= 1'b1;
            r_mem_addr <= r_rd_ptr + ADDR_ONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
